// File: rtl/gf_mult_pkg.sv
// Shared types and helpers for the sequential integer / carry-less multiplier.
package gf_mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic MODE_CLMUL = 1'b0;
    localparam logic MODE_INT   = 1'b1;

    function automatic int num_digits(input int w, input int d);
        return w / d;
    endfunction

endpackage

// File: rtl/gf_digit_step.sv
// One digit of shift-and-combine: folds each selected shift of a_shifted into the accumulator,
// by 2W-bit addition (integer mode) or XOR (carry-less mode).
module gf_digit_step
    import gf_mult_pkg::*;
#(
    parameter int ACC_WIDTH   = 64,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic [ACC_WIDTH-1:0]   acc_in,
    input  logic [ACC_WIDTH-1:0]   a_shifted,
    input  logic [DIGIT_WIDTH-1:0] digit,
    input  logic                   mode,
    output logic [ACC_WIDTH-1:0]   acc_out
);

    logic [ACC_WIDTH-1:0] partial;

    always_comb begin
        acc_out = acc_in;
        partial = '0;
        for (int j = 0; j < DIGIT_WIDTH; j++) begin
            partial = a_shifted << j;
            if (digit[j]) begin
                if (mode == MODE_INT) begin
                    acc_out = acc_out + partial;
                end else begin
                    acc_out = acc_out ^ partial;
                end
            end
        end
    end

endmodule

// File: rtl/gf_seq_multiplier.sv
// Iterative W x W -> 2W multiplier (integer or carry-less), DIGIT_WIDTH multiplier bits per cycle.
// Define GF_REDUCE_EN to add GF(2^W) reduction by a latched polynomial (poly / red_out ports).
module gf_seq_multiplier
    import gf_mult_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DIGIT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    carry_option,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
`ifdef GF_REDUCE_EN
    input  logic [DATA_WIDTH-1:0]   poly,
    output logic [DATA_WIDTH-1:0]   red_out,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] mult_out,
    output logic                    busy,
    output state_t                  state_dbg
);

    localparam int TWO_W      = 2 * DATA_WIDTH;
    localparam int NUM_DIGITS = num_digits(DATA_WIDTH, DIGIT_WIDTH);
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    if (DATA_WIDTH % DIGIT_WIDTH != 0) begin : g_bad_digit
        $error("DATA_WIDTH must be a multiple of DIGIT_WIDTH");
    end

    state_t               state_q, state_d;
    logic [TWO_W-1:0]     acc_q, acc_d;
    logic [TWO_W-1:0]     a_sh_q, a_sh_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                 mode_q, mode_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [TWO_W-1:0]       step_a;
    logic [DIGIT_WIDTH-1:0] step_digit;
    logic                   step_mode;
    logic [TWO_W-1:0]       step_out;
    logic                   accept;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a held result stays stable until out_ready is seen.
    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL) | (state_q == REDUCE);
    assign state_dbg = state_q;
    assign accept    = in_valid & in_ready;

`ifdef GF_REDUCE_EN
    logic [TWO_W-1:0]       prod_q, prod_d;
    logic [TWO_W-1:0]       p_sh_q, p_sh_d;
    logic [TWO_W-1:0]       red_tmp;
    logic [DIGIT_WIDTH-1:0] red_win;
    logic [DIGIT_WIDTH-1:0] quot;
    int                     red_lo;

    // Bits inside one digit depend on folds of the higher bits, so derive the quotient digit
    // serially, then let the shared step apply it as a carry-less multiply of the shifted poly.
    always_comb begin
        red_lo  = TWO_W - (int'(cnt_q) + 1) * DIGIT_WIDTH;
        red_tmp = acc_q;
        red_win = '0;
        quot    = '0;
        for (int k = DIGIT_WIDTH - 1; k >= 0; k--) begin
            red_win = DIGIT_WIDTH'(red_tmp >> red_lo);
            if (red_win[k]) begin
                quot[k] = 1'b1;
                red_tmp = red_tmp ^ (p_sh_q << k);
            end
        end
    end

    assign mult_out = prod_q;
    assign red_out  = acc_q[DATA_WIDTH-1:0];
`else
    assign mult_out = acc_q;
`endif

    gf_digit_step #(
        .ACC_WIDTH  (TWO_W),
        .DIGIT_WIDTH(DIGIT_WIDTH)
    ) u_step (
        .acc_in   (acc_q),
        .a_shifted(step_a),
        .digit    (step_digit),
        .mode     (step_mode),
        .acc_out  (step_out)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        a_sh_d     = a_sh_q;
        b_d        = b_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        step_a     = a_sh_q;
        step_digit = b_q[DIGIT_WIDTH-1:0];
        step_mode  = mode_q;
`ifdef GF_REDUCE_EN
        prod_d     = prod_q;
        p_sh_d     = p_sh_q;
        if (state_q == REDUCE) begin
            step_a     = p_sh_q;
            step_digit = quot;
            step_mode  = MODE_CLMUL;
        end
`endif

        case (state_q)
            MUL: begin
                acc_d  = step_out;
                a_sh_d = a_sh_q << DIGIT_WIDTH;
                b_d    = b_q >> DIGIT_WIDTH;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIGIT) begin
                    cnt_d   = '0;
`ifdef GF_REDUCE_EN
                    prod_d  = step_out;
                    state_d = (mode_q == MODE_CLMUL) ? REDUCE : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef GF_REDUCE_EN
            REDUCE: begin
                acc_d  = step_out;
                p_sh_d = p_sh_q >> DIGIT_WIDTH;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_DIGIT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A DONE-state accept overrides the return to IDLE: back-to-back with no bubble.
        if (accept) begin
            state_d = MUL;
            acc_d   = '0;
            cnt_d   = '0;
            a_sh_d  = {{DATA_WIDTH{1'b0}}, a};
            b_d     = b;
            mode_d  = carry_option;
`ifdef GF_REDUCE_EN
            p_sh_d  = TWO_W'({1'b1, poly}) << (DATA_WIDTH - DIGIT_WIDTH);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_sh_q  <= '0;
            b_q     <= '0;
            mode_q  <= MODE_CLMUL;
            cnt_q   <= '0;
`ifdef GF_REDUCE_EN
            prod_q  <= '0;
            p_sh_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_sh_q  <= a_sh_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
`ifdef GF_REDUCE_EN
            prod_q  <= prod_d;
            p_sh_q  <= p_sh_d;
`endif
        end
    end

endmodule

// File: tb/tb_gf_seq_multiplier.sv
// Directed and random checks of gf_seq_multiplier: an 8-bit/2-bit-digit instance for the
// directed steps and a 32-bit/4-bit-digit instance for random traffic with output stalls.
module tb_gf_seq_multiplier;
  import gf_mult_pkg::*;

  localparam int N8 = 4;
`ifdef GF_REDUCE_EN
  localparam bit RED_EN = 1'b1;
`else
  localparam bit RED_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] mult_out8;
  state_t      state8;
  logic        in_valid32, in_ready32, mode32, out_valid32, out_ready32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] mult_out32;
  state_t      state32;
`ifdef GF_REDUCE_EN
  logic [7:0]  poly8, red_out8;
  logic [31:0] poly32, red_out32;
`endif

  gf_seq_multiplier #(.DATA_WIDTH(8), .DIGIT_WIDTH(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .carry_option(mode8), .a(a8), .b(b8),
`ifdef GF_REDUCE_EN
    .poly(poly8), .red_out(red_out8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .mult_out(mult_out8),
    .busy(busy8), .state_dbg(state8)
  );

  gf_seq_multiplier #(.DATA_WIDTH(32), .DIGIT_WIDTH(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .carry_option(mode32), .a(a32), .b(b32),
`ifdef GF_REDUCE_EN
    .poly(poly32), .red_out(red_out32),
`endif
    .out_valid(out_valid32), .out_ready(out_ready32), .mult_out(mult_out32),
    .busy(busy32), .state_dbg(state32)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] clmul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (y[i]) r = r ^ (64'(x) << i);
    end
    return r;
  endfunction

  function automatic logic [7:0] gf8_reduce(input logic [15:0] p, input logic [7:0] poly);
    logic [15:0] t;
    t = p;
    for (int i = 15; i >= 8; i--) begin
      if (t[i]) t = t ^ (16'({1'b1, poly}) << (i - 8));
    end
    return t[7:0];
  endfunction

  // ---------------- scoreboards ----------------
  logic [15:0] exp8_q[$];
  logic [63:0] exp32_q[$];
  logic [15:0] m8_prod, e8;
  logic [63:0] m8_cl, e32;
`ifdef GF_REDUCE_EN
  logic [7:0]  red8_q[$];
  logic [7:0]  e8_red;
`endif

  always @(negedge clk) begin
    if (rst) begin
      exp8_q.delete();
`ifdef GF_REDUCE_EN
      red8_q.delete();
`endif
    end else begin
      if (out_valid8 && out_ready8) begin
        check("pending8", 64'(exp8_q.size() != 0), 64'd1);
        if (exp8_q.size() != 0) begin
          e8 = exp8_q.pop_front();
          check("sb_mult_out8", 64'(mult_out8), 64'(e8));
`ifdef GF_REDUCE_EN
          e8_red = red8_q.pop_front();
          check("sb_red_out8", 64'(red_out8), 64'(e8_red));
`endif
        end
      end
      if (in_valid8 && in_ready8) begin
        m8_cl   = clmul(32'(a8), 32'(b8));
        m8_prod = (mode8 == MODE_INT) ? 16'(16'(a8) * 16'(b8)) : m8_cl[15:0];
        exp8_q.push_back(m8_prod);
`ifdef GF_REDUCE_EN
        red8_q.push_back((mode8 == MODE_INT) ? m8_prod[7:0] : gf8_reduce(m8_prod, poly8));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp32_q.delete();
    end else begin
      if (out_valid32 && out_ready32) begin
        check("pending32", 64'(exp32_q.size() != 0), 64'd1);
        if (exp32_q.size() != 0) begin
          e32 = exp32_q.pop_front();
          check("sb_mult_out32", mult_out32, e32);
        end
      end
      if (in_valid32 && in_ready32) begin
        exp32_q.push_back((mode32 == MODE_INT) ? 64'(a32) * 64'(b32) : clmul(a32, b32));
      end
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic mode, output int waited);
    a8 = a; b8 = b; mode8 = mode; in_valid8 = 1'b1;
    waited = 0;
    while (waited < 200) begin
      @(negedge clk);
      waited++;
      if (in_ready8) break;
    end
    if (!in_ready8) check("accept_timeout8", 64'(in_ready8), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic mode, output int waited);
    a32 = a; b32 = b; mode32 = mode; in_valid32 = 1'b1;
    waited = 0;
    while (waited < 400) begin
      @(negedge clk);
      waited++;
      if (in_ready32) break;
    end
    if (!in_ready32) check("accept_timeout32", 64'(in_ready32), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic mode, input logic [15:0] prod_lit);
    int c, lat, exp_lat;
    exp_lat = (mode == MODE_CLMUL && RED_EN) ? 2 * N8 : N8;
    send8(a, b, mode, c);
    in_valid8 = 1'b0;
    lat = 0;
    while (lat <= 50) begin
      @(negedge clk);
      if (out_valid8) break;
      lat++;
    end
    check("latency8", 64'(lat), 64'(exp_lat));
    check("prod_lit8", 64'(mult_out8), 64'(prod_lit));
    @(posedge clk); #1;
  endtask

  task automatic drain8();
    in_valid8 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp8_q.size() == 0 && !out_valid8) break;
    end
    check("drain8", 64'(exp8_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  logic rand_done = 1'b0;

  initial begin
    int c, lat, seen;
    logic [31:0] ra, rb;

    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; mode8 = 1'b0; out_ready8 = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; mode32 = 1'b0; out_ready32 = 1'b1;
`ifdef GF_REDUCE_EN
    poly8 = 8'h1B; poly32 = 32'h0000_008D;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready8), 64'd1);
    check("reset_out_valid", 64'(out_valid8), 64'd0);
    check("reset_busy", 64'(busy8), 64'd0);
    check("reset_mult_out", 64'(mult_out8), 64'd0);
    check("reset_state", 64'(state8), 64'(IDLE));
    @(posedge clk); #1;

    // single transactions with fixed latency
    run8(8'h03, 8'h03, MODE_CLMUL, 16'h0005);
    run8(8'h03, 8'h03, MODE_INT,   16'h0009);
    run8(8'hFF, 8'hFF, MODE_INT,   16'hFE01);
    run8(8'hFF, 8'hFF, MODE_CLMUL, 16'h5555);
    run8(8'h00, 8'hFF, MODE_INT,   16'h0000);

    // back-to-back: in_valid held across three pairs
    out_ready8 = 1'b1;
    send8(8'h12, 8'h34, MODE_INT, c);
    send8(8'hA5, 8'h5A, MODE_INT, c);
    check("b2b_gap1", 64'(c), 64'(N8 + 1));
    send8(8'hC3, 8'h3C, MODE_CLMUL, c);
    check("b2b_gap2", 64'(c), 64'(N8 + 1));
    drain8();

    // output stall: result held, no accept while out_ready is low
    out_ready8 = 1'b0;
    send8(8'h0F, 8'hF0, MODE_INT, c);
    a8 = 8'h21; b8 = 8'h43; mode8 = MODE_CLMUL;
    lat = 0;
    while (lat <= 50) begin
      @(negedge clk);
      if (out_valid8) break;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_mult_out", 64'(mult_out8), 64'h0E10);
      check("stall_in_ready", 64'(in_ready8), 64'd0);
      check("stall_out_valid", 64'(out_valid8), 64'd1);
    end
    @(posedge clk); #1;
    out_ready8 = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk); #1;
    drain8();

    // reset during the second MUL cycle aborts silently
    send8(8'h57, 8'h83, MODE_CLMUL, c);
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_state", 64'(state8), 64'(IDLE));
    check("abort_out_valid", 64'(out_valid8), 64'd0);
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_mult_out", 64'(mult_out8), 64'd0);
    check("abort_in_ready", 64'(in_ready8), 64'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid8) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    @(posedge clk); #1;
    run8(8'h57, 8'h83, MODE_CLMUL, 16'h2B79);
    run8(8'h57, 8'h83, MODE_INT,   16'h2C85);

`ifdef GF_REDUCE_EN
    send8(8'h57, 8'h83, MODE_CLMUL, c);
    in_valid8 = 1'b0;
    lat = 0;
    while (lat <= 50) begin
      @(negedge clk);
      if (out_valid8) break;
      lat++;
    end
    check("red_latency8", 64'(lat), 64'(2 * N8));
    check("red_mult_out8", 64'(mult_out8), 64'h2B79);
    check("red_out8", 64'(red_out8), 64'hC1);
    @(posedge clk); #1;
`endif

    // random traffic on the 32-bit instance with random output stalls
    fork
      begin
        for (int t = 0; t < 1000; t++) begin
          case ($urandom_range(0, 7))
            0: ra = 32'h0;
            1: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
          endcase
          case ($urandom_range(0, 7))
            0: rb = 32'h0;
            1: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
          endcase
          send32(ra, rb, 1'($urandom_range(0, 1)), c);
          if ($urandom_range(0, 3) == 0) begin
            in_valid32 = 1'b0;
            @(posedge clk); #1;
          end
        end
        in_valid32 = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready32 = ($urandom_range(0, 3) != 0);
        end
        out_ready32 = 1'b1;
      end
    join

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp32_q.size() == 0 && !out_valid32) break;
    end
    check("drain32", 64'(exp32_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
